// File: rtl/dct_cl_quant_pkg.sv
// Shared widths, cosine / quantization tables and FSM encoding for the
// 8x8 DCT + JPEG luminance quantizer.
package dct_cl_quant_pkg;

   localparam int S_W    = 9;                  // level-shifted pixel, signed
   localparam int C_W    = 16;                 // cosine constant, signed, 14 frac bits
   localparam int T_FRAC = 7;                  // fractional bits kept in row results
   localparam int T_W    = 20;                 // row-result storage width
   localparam int ACC_W  = 40;                 // dot-product accumulator width
   localparam int R_FRAC = 16;                 // reciprocals are scaled by 2^16
   localparam int R_W    = 16;                 // reciprocal width (largest is 6554)
   localparam int PROD_W = ACC_W + R_W + 1;    // F * R, reciprocal zero-extended
   localparam int QV_W   = 16;                 // stored quantized coefficient width

   typedef enum logic [1:0] {IDLE, ROW, COL, DONE} state_t;

   // C[k][n] = round(2^14 * c(k) * cos((2n+1)k*pi/16))
   localparam int C_TAB [8][8] = '{
      '{ 5793,  5793,  5793,  5793,  5793,  5793,  5793,  5793},
      '{ 8035,  6811,  4551,  1598, -1598, -4551, -6811, -8035},
      '{ 7568,  3135, -3135, -7568, -7568, -3135,  3135,  7568},
      '{ 6811, -1598, -8035, -4551,  4551,  8035,  1598, -6811},
      '{ 5793, -5793, -5793,  5793,  5793, -5793, -5793,  5793},
      '{ 4551, -8035,  1598,  6811, -6811, -1598,  8035, -4551},
      '{ 3135, -7568,  7568, -3135, -3135,  7568, -7568,  3135},
      '{ 1598, -4551,  6811, -8035,  8035, -6811,  4551, -1598}
   };

   // Standard JPEG luminance quantization table, Q[v][u]
   localparam int Q_TAB [8][8] = '{
      '{16, 11, 10, 16,  24,  40,  51,  61},
      '{12, 12, 14, 19,  26,  58,  60,  55},
      '{14, 13, 16, 24,  40,  57,  69,  56},
      '{14, 17, 22, 29,  51,  87,  80,  62},
      '{18, 22, 37, 56,  68, 109, 103,  77},
      '{24, 35, 55, 64,  81, 104, 113,  92},
      '{49, 64, 78, 87, 103, 121, 120, 101},
      '{72, 92, 95, 98, 112, 100, 103,  99}
   };

   typedef logic [7:0][7:0][R_W-1:0] r_tab_t;

   // R[v][u] = round(2^16 / Q[v][u]); no Q entry produces an exact half
   function automatic r_tab_t make_r_tab();
      r_tab_t t;
      t = '0;
      for (int v = 0; v < 8; v++) begin
         for (int u = 0; u < 8; u++) begin
            t[v][u] = R_W'(((1 << R_FRAC) + Q_TAB[v][u] / 2) / Q_TAB[v][u]);
         end
      end
      return t;
   endfunction

   localparam r_tab_t R_TAB = make_r_tab();

endpackage

// File: rtl/dct_dot8.sv
// Eight-term signed dot product; optionally rounds and arithmetic-shifts
// the sum right by RND_SHIFT bits (round half up, i.e. floor(x + 0.5)).
module dct_dot8 #(
   parameter int A_W       = 20,
   parameter int B_W       = 16,
   parameter int ACC_W     = 40,
   parameter int RND_SHIFT = 7
) (
   input  logic                    round_en,
   input  logic [7:0][A_W-1:0]     a,
   input  logic [7:0][B_W-1:0]     b,
   output logic signed [ACC_W-1:0] y
);

   localparam logic [ACC_W-1:0] RND = {{(ACC_W-1){1'b0}}, 1'b1} << (RND_SHIFT - 1);

   logic signed [A_W+B_W-1:0] prod;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   acc_r;

   // Accumulate sign-extended products, then apply the optional rounding shift
   always_comb begin
      prod = '0;
      acc  = '0;
      for (int i = 0; i < 8; i++) begin
         prod = $signed(a[i]) * $signed(b[i]);
         acc  = acc + {{(ACC_W-A_W-B_W){prod[A_W+B_W-1]}}, prod};
      end
      acc_r = acc + RND;
      y     = round_en ? (acc_r >>> RND_SHIFT) : acc;
   end

endmodule

// File: rtl/dct_cl_quantizer.sv
// 8x8 forward DCT with JPEG luminance quantization. One shared dot-product
// unit computes the row pass (64 cycles) and then the column pass (64
// cycles); each column result is quantized as it is produced.
module dct_cl_quantizer #(
   parameter int IN_FRAC   = 8,
   parameter int COEF_FRAC = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0][7:0][31:0]  mcu,
   output logic                   out_valid,
   output logic [7:0][7:0][31:0]  dct
);

   import dct_cl_quant_pkg::*;

   // Handshake: a block is accepted on a rising edge where in_valid && in_ready;
   // in_ready is high only while idle, out_valid is a one-cycle pulse in DONE.

   localparam int ROW_SHIFT = COEF_FRAC - T_FRAC;          // row results keep 7 frac bits
   localparam int Q_SHIFT   = R_FRAC + T_FRAC + COEF_FRAC; // F has 21 frac bits, R has 16
   localparam logic [PROD_W-1:0] Q_RND = PROD_W'(1) << (Q_SHIFT - 1);

   state_t state_q, state_d;
   logic [5:0] cnt_q, cnt_d;
   logic [2:0] hi, lo;

   logic [7:0][7:0][S_W-1:0]  s_in;
   logic [7:0][7:0][S_W-1:0]  s_buf;
   logic [63:0][T_W-1:0]      t_buf;
   logic [7:0][7:0][QV_W-1:0] q_buf;
   logic [7:0][7:0][31:0]     dct_d;

   logic [7:0][T_W-1:0]       op_a;
   logic [7:0][C_W-1:0]       op_b;
   logic                      round_en;
   logic signed [ACC_W-1:0]   dot_y;

   logic signed [PROD_W-1:0]  prod;
   logic [PROD_W-1:0]         mag;
   logic [QV_W-1:0]           q_mag;
   logic [QV_W-1:0]           q_val;
   logic [7:0]                pix;
   logic                      unused_frac;

   // Row pass walks T[y][u]; column pass walks F[v][u]; both y/v-major
   assign hi = cnt_q[5:3];
   assign lo = cnt_q[2:0];

   // Fraction bits of the samples do not contribute to the pixel value
   assign unused_frac = ^mcu;

   // Pixel decode: saturate integer part to 255, then level-shift by 128
   always_comb begin
      s_in = '0;
      pix  = '0;
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            pix = (|mcu[y][x][31:IN_FRAC+8]) ? 8'hff : mcu[y][x][IN_FRAC+7:IN_FRAC];
            s_in[y][x] = {1'b0, pix} - 9'd128;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next-state, cycle counter and handshake outputs
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = ROW;
               cnt_d   = '0;
            end
         end
         ROW: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd63) state_d = COL;
         end
         COL: begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd63) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Operand select for the shared dot product: pixels x cosines in ROW,
   // cosines x stored row results in COL
   always_comb begin
      op_a     = '0;
      op_b     = '0;
      round_en = 1'b0;
      if (state_q == COL) begin
         for (int i = 0; i < 8; i++) begin
            op_a[i] = t_buf[{3'(i), lo}];
            op_b[i] = C_W'(C_TAB[hi][i]);
         end
      end else begin
         round_en = 1'b1;
         for (int i = 0; i < 8; i++) begin
            op_a[i] = {{(T_W-S_W){s_buf[hi][i][S_W-1]}}, s_buf[hi][i]};
            op_b[i] = C_W'(C_TAB[lo][i]);
         end
      end
   end

   dct_dot8 #(
      .A_W       (T_W),
      .B_W       (C_W),
      .ACC_W     (ACC_W),
      .RND_SHIFT (ROW_SHIFT)
   ) u_dot (
      .round_en (round_en),
      .a        (op_a),
      .b        (op_b),
      .y        (dot_y)
   );

   // Quantize F[v][u]: multiply by the reciprocal, round half away from zero
   always_comb begin
      prod  = dot_y * $signed({1'b0, R_TAB[hi][lo]});
      mag   = prod[PROD_W-1] ? PROD_W'(-prod) : PROD_W'(prod);
      q_mag = QV_W'((mag + Q_RND) >> Q_SHIFT);
      q_val = prod[PROD_W-1] ? QV_W'(-q_mag) : q_mag;
   end

   // Next output block: stored results plus the final coefficient of this cycle
   always_comb begin
      dct_d = '0;
      for (int v = 0; v < 8; v++) begin
         for (int u = 0; u < 8; u++) begin
            dct_d[v][u] = {{(32-QV_W){q_buf[v][u][QV_W-1]}}, q_buf[v][u]};
         end
      end
      dct_d[7][7] = {{(32-QV_W){q_val[QV_W-1]}}, q_val};
   end

   // Datapath storage: accepted pixels, row results, quantized scratch, output
   always_ff @(posedge clk) begin
      if (rst) begin
         s_buf <= '0;
         t_buf <= '0;
         q_buf <= '0;
         dct   <= '0;
      end else begin
         if (state_q == IDLE && in_valid) s_buf <= s_in;
         if (state_q == ROW) t_buf[cnt_q] <= T_W'(dot_y);
         if (state_q == COL) q_buf[hi][lo] <= q_val;
         if (state_q == COL && cnt_q == 6'd63) dct <= dct_d;
      end
   end

endmodule

// File: tb/tb_dct_cl_quantizer.sv
// Directed bench for dct_cl_quantizer: hand-computed coefficient blocks,
// handshake timing, busy-time in_valid pulses and mid-block reset.
module tb_dct_cl_quantizer;

   localparam int K_MID   = 0;  // all 0x8000 -> all zero
   localparam int K_HI    = 1;  // all 0xff00 -> dc 64
   localparam int K_SAT   = 2;  // all 0x0001_0000 -> same as K_HI
   localparam int K_ACOL  = 3;  // 0xff00 on even x
   localparam int K_ACOLN = 4;  // 0xff00 on odd x
   localparam int K_AROW  = 5;  // 0xff00 on even y

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [7:0][7:0][31:0] mcu;
   logic                  out_valid;
   logic [7:0][7:0][31:0] dct;

   int n_vec  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   // Clock
   always #5 clk = ~clk;

   dct_cl_quantizer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mcu       (mcu),
      .out_valid (out_valid),
      .dct       (dct)
   );

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic fill(input int kind);
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            case (kind)
               K_MID:   mcu[y][x] = 32'h0000_8000;
               K_HI:    mcu[y][x] = 32'h0000_ff00;
               K_SAT:   mcu[y][x] = 32'h0001_0000;
               K_ACOL:  mcu[y][x] = (x % 2 == 0) ? 32'h0000_ff00 : 32'h0;
               K_ACOLN: mcu[y][x] = (x % 2 == 1) ? 32'h0000_ff00 : 32'h0;
               K_AROW:  mcu[y][x] = (y % 2 == 0) ? 32'h0000_ff00 : 32'h0;
               default: mcu[y][x] = 32'h0;
            endcase
         end
      end
   endtask

   // Expected coefficients, pushed in dct[v][u] order (v-major)
   task automatic push_exp(input int kind);
      int acol[8] = '{0, 17, 0, 14, 0, 8, 0, 15};
      int arow[8] = '{0, 15, 0, 15, 0, 14, 0, 13};
      int e;
      for (int v = 0; v < 8; v++) begin
         for (int u = 0; u < 8; u++) begin
            e = 0;
            case (kind)
               K_HI, K_SAT: e = (v == 0 && u == 0) ? 64 : 0;
               K_ACOL:      e = (v == 0) ? acol[u] : 0;
               K_ACOLN:     e = (v == 0) ? -acol[u] : 0;
               K_AROW:      e = (u == 0) ? arow[v] : 0;
               default:     e = 0;
            endcase
            exp_q.push_back(32'(e));
         end
      end
   endtask

   task automatic check_dct(input string name);
      logic [31:0] e;
      for (int v = 0; v < 8; v++) begin
         for (int u = 0; u < 8; u++) begin
            e = exp_q.pop_front();
            check($sformatf("%s dct[%0d][%0d]", name, v, u), dct[v][u], e);
         end
      end
   endtask

   // One full transaction: accept, wait for out_valid, compare, check the pulse ends
   task automatic run_block(input int kind, input string name);
      int cycles;
      fill(kind);
      in_valid = 1'b1;
      check({name, " in_ready before accept"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < 300) begin
         step();
         cycles++;
      end
      check({name, " latency"}, 32'(cycles), 32'd128);
      check({name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
      push_exp(kind);
      check_dct(name);
      step();
      check({name, " out_valid single cycle"}, 32'(out_valid), 32'd0);
      check({name, " in_ready after DONE"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int pulses;
      rst      = 1'b1;
      in_valid = 1'b0;
      fill(K_MID);
      repeat (3) step();
      rst = 1'b0;

      // Reset state
      check("reset in_ready", 32'(in_ready), 32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      push_exp(K_MID);
      check_dct("reset");
      step();

      // Main function across input patterns
      run_block(K_MID, "flat_mid");
      run_block(K_HI, "flat_hi");
      run_block(K_ACOL, "alt_col");
      run_block(K_ACOLN, "alt_col_neg");
      run_block(K_AROW, "alt_row");
      run_block(K_SAT, "saturate");

      // Cycle-by-cycle timing with in_valid pulses (carrying a different block) while busy
      fill(K_ACOL);
      in_valid = 1'b1;
      step();
      fill(K_MID);
      for (int i = 0; i <= 129; i++) begin
         check($sformatf("timing out_valid t+%0d", i + 1), 32'(out_valid), (i == 128) ? 32'd1 : 32'd0);
         check($sformatf("timing in_ready t+%0d", i + 1), 32'(in_ready), (i == 129) ? 32'd1 : 32'd0);
         if (i < 129) begin
            in_valid = (i % 2 == 0);
            step();
         end
      end
      in_valid = 1'b0;
      repeat (3) step();
      push_exp(K_ACOL);
      check_dct("timing hold");

      // Reset on the 70th edge after accept discards the block
      fill(K_HI);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (69) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midreset out_valid", 32'(out_valid), 32'd0);
      check("midreset in_ready", 32'(in_ready), 32'd1);
      push_exp(K_MID);
      check_dct("midreset");
      pulses = 0;
      for (int i = 0; i < 150; i++) begin
         if (out_valid === 1'b1) pulses++;
         step();
      end
      check("midreset no out_valid", 32'(pulses), 32'd0);
      run_block(K_AROW, "after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/dct_cl_quantizer.md
DCT_CL_QUANTIZER -- requirements
Module: dct_cl_quantizer

Interface
REQ-001 The block SHALL have parameter IN_FRAC, default 8, giving the fractional bits of each mcu sample (Q24.8).
REQ-002 The block SHALL have parameter COEF_FRAC, default 14, giving the fractional bits of the signed cosine constants.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: mcu holds a block to transform.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a new mcu.
REQ-007 The block SHALL have port mcu, input, [7:0][7:0][31:0]: 8x8 pixel block, mcu[y][x], unsigned Q24.8.
REQ-008 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse when dct holds a new result.
REQ-009 The block SHALL have port dct, output, [7:0][7:0][31:0]: quantized coefficients dct[v][u], signed two's complement integers.

Function
REQ-010 An accept SHALL occur on an edge where in_valid && in_ready; mcu SHALL be registered on that edge, and in_valid SHALL be ignored otherwise.
REQ-011 The FSM SHALL use states IDLE -> ROW (64 cycles) -> COL (64 cycles) -> DONE (1 cycle) -> IDLE, and in_ready SHALL be 1 only in IDLE.
REQ-012 out_valid SHALL be 1 only in DONE, exactly 129 cycles after the accept edge, and dct SHALL update on entry to DONE and hold until the next DONE.
REQ-013 Pixel decode: p = mcu[31:16] != 0 ? 255 : mcu[15:8] (saturate; fraction bits [7:0] ignored); s = p - 128, 9-bit signed.
REQ-014 The cosine constants SHALL be C[k][n] = round(2^14 * c(k) * cos((2n+1)k*pi/16)), with c(0) = sqrt(1/8) and c(k>0) = 1/2, each 16-bit signed.
REQ-015 ROW SHALL compute one T[y][u] per cycle, in y-major then u order: T = (sum_x s[y][x]*C[u][x] + 2^6) >>> 7, signed, keeping 7 fractional bits.
REQ-016 COL SHALL compute one F[v][u] per cycle: F = sum_y C[v][y]*T[y][u], with 21 fractional bits and at least 40-bit accumulation.
REQ-017 Quantization SHALL use the standard JPEG luminance table Q[v][u] (row 0: 16 11 10 16 24 40 51 61) with R[v][u] = round(2^16/Q[v][u]).
REQ-018 The quantized value SHALL be dct[v][u] = round-half-away-from-zero(F*R / 2^37), sign-extended to 32 bits.
REQ-019 Results SHALL be bit-exact to REQ-013..018 and within +/-1 of floating-point round(DCT/Q).
REQ-020 No intermediate SHALL overflow for any legal input; no saturation is needed beyond REQ-013.

Reset
REQ-021 When rst is sampled high, the FSM SHALL go to IDLE, out_valid SHALL be 0, dct SHALL be all zero, counters and scratch SHALL be cleared, and in_ready SHALL be 1 from the first cycle after reset.
REQ-022 A reset mid-operation (ROW/COL/DONE) SHALL discard the block without producing out_valid.

Structure
REQ-023 Package dct_cl_quant_pkg SHALL hold the C, Q and R tables, the width constants and the FSM state enum.
REQ-024 A sub-module dct_dot8 SHALL implement the 8-term signed dot product, with the shift and rounding set by parameter, and SHALL be instantiated once and shared by ROW and COL.
REQ-025 T SHALL be stored as a 64-entry register array of at least 20 bits each.

Verification
REQ-026 Alternating columns: mcu[y][x] = 32'hff00 for even x and 0 for odd x, all rows -> dct row 0 = [0,17,0,14,0,8,0,15] (+/-1), all other rows 0.
REQ-027 Flat block: all mcu = 32'h8000 -> all dct = 0.
REQ-028 Flat block: all mcu = 32'hff00 -> dct[0][0] = 64 (1016/16 = 63.5 rounds away from zero), all others 0.
REQ-029 Timing: accept at edge t -> out_valid high only in cycle t+129, in_ready low from t+1 to t+129, and in_valid pulses while busy have no effect.
REQ-030 Reset at cycle 70 after accept -> no out_valid, dct = 0, and a following accept completes normally.
REQ-031 Saturation: all mcu = 32'h0001_0000 -> same result as all 32'hff00.
